wb_seq: RTL and testbench
=========================

// Module: wb_seq
// PURPOSE
//   Parametrised writeback sequencer for the WB stage. Registers all register-file write requests.
//   Single-write ops (DP results, loads) and BL link writes are handled as in the combinational decoder.
//   Adds LDM-style block writeback: one register-list entry per cycle, with an accept/ready handshake
//   towards MEM and a per-word valid handshake for load data.
// PARAMETERS
//   FULLW   32  datapath / register word width
//   REGAW   4   register address width
//   NREG    16  register count (= 2**REGAW); width of the register list
//   LR_IDX  14  link register index written by BL
//   PC_INC  4   added to the instruction address to form the link value
// PORTS
//   clk         in   1      clock, rising edge
//   rst         in   1      asynchronous reset, active-high
//   in_valid    in   1      MEM stage presents a WB request
//   in_ready    out  1      sequencer can accept a request this cycle
//   in_kind     in   2      0=NOWR, 1=SINGLE, 2=LINK, 3=MULTI
//   in_rd       in   REGAW  destination register (SINGLE)
//   in_data     in   FULLW  write data (SINGLE)
//   in_pc       in   FULLW  instruction address (LINK)
//   in_reglist  in   NREG   register mask (MULTI); bit i = register i
//   ld_valid    in   1      one load word is present on ld_data (MULTI only)
//   ld_data     in   FULLW  load word for the next register in the list
//   reg_we      out  1      register-file write enable
//   reg_wa      out  REGAW  register-file write address
//   reg_wd      out  FULLW  register-file write data
//   busy        out  1      MULTI transfer in progress
//   done        out  1      one-cycle pulse when a request completes
// BEHAVIOUR
//   Reset: state=IDLE; reg_we=0, reg_wa=0, reg_wd=0, done=0, busy=0, remaining mask cleared.
//     Reset is async and aborts any MULTI in flight; no partial write is issued after reset.
//   reg_we/reg_wa/reg_wd/done are registered. reg_we is high for exactly one cycle per write.
//   States IDLE, MULTI. in_ready = (state==IDLE); busy = (state==MULTI).
//   Accept = in_valid & in_ready. On accept, the result is visible on the next edge (1-cycle latency):
//     NOWR:   reg_we=0, done=1.
//     SINGLE: reg_we=1, wa=in_rd, wd=in_data, done=1.
//     LINK:   reg_we=1, wa=LR_IDX, wd=in_pc+PC_INC (mod 2**FULLW; wrap is silent), done=1.
//     MULTI, in_reglist==0: behaves as NOWR (done=1, stays IDLE).
//     MULTI, in_reglist!=0: latch mask into rem, go to MULTI; no write on this edge.
//   MULTI: idx = lowest set bit of rem.
//     ld_valid=1: reg_we=1, wa=idx, wd=ld_data; clear rem[idx].
//       If that was the last set bit: done=1 and -> IDLE on the same edge (in_ready high the cycle the
//       final write is visible).
//     ld_valid=0: reg_we=0; hold state and rem (stall, no timeout).
//   Writes are issued in ascending register order, one per accepted load word; words are never dropped.
//   ld_valid in IDLE is ignored. in_valid in MULTI is not accepted (in_ready=0); MEM must hold it.
//   Undefined in_kind never occurs (all 2-bit codes are defined).
//   Back-to-back SINGLE/LINK/NOWR: one request accepted per cycle, one output per cycle.
// TESTING
//   rst mid-MULTI (after 2 of 4 words) -> reg_we=0, busy=0, in_ready=1 immediately; no further writes.
//   SINGLE rd=3 data=0xDEADBEEF -> next cycle: we=1, wa=3, wd=0xDEADBEEF, done=1; then we=0.
//   LINK pc=0x100 -> we=1, wa=14, wd=0x104; pc=0xFFFFFFFC -> wd=0x00000000.
//   MULTI list=0x8011; ld_valid pattern 1,0,1,1 with words A,B,C
//     -> writes r0=A, (stall), r4=B, r15=C; done with the r15 write; in_ready=0 until then.
//   MULTI list=0x0000 -> done=1, no write, busy never asserted.
//   in_valid SINGLE held during MULTI -> not accepted; accepted the cycle in_ready rises; write 1 cycle later.

Source files
------------

// File: rtl/wb_seq.sv
// Writeback sequencer: registers single/link register-file writes and walks LDM-style
// register lists one load word per cycle.
//
// state | meaning
// IDLE  | accepting requests; single/link/no-write results issued one edge after accept
// MULTI | walking the latched register list, one write per valid load word
module wb_seq #(
    parameter int FULLW  = 32,
    parameter int REGAW  = 4,
    parameter int NREG   = 16,
    parameter int LR_IDX = 14,
    parameter int PC_INC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [REGAW-1:0] in_rd,
    input  logic [FULLW-1:0] in_data,
    input  logic [FULLW-1:0] in_pc,
    input  logic [NREG-1:0]  in_reglist,
    input  logic             ld_valid,
    input  logic [FULLW-1:0] ld_data,
    output logic             reg_we,
    output logic [REGAW-1:0] reg_wa,
    output logic [FULLW-1:0] reg_wd,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        MULTI = 1'b1
    } state_t;

    localparam logic [1:0] KIND_NOWR   = 2'd0;
    localparam logic [1:0] KIND_SINGLE = 2'd1;
    localparam logic [1:0] KIND_LINK   = 2'd2;

    state_t           state, state_nx;
    logic [NREG-1:0]  rem, rem_nx;
    logic [NREG-1:0]  rem_clr;
    logic [REGAW-1:0] low_idx;
    logic             reg_we_nx;
    logic [REGAW-1:0] reg_wa_nx;
    logic [FULLW-1:0] reg_wd_nx;
    logic             done_nx;

    assign in_ready = (state == IDLE);
    assign busy     = (state == MULTI);

    // Descending scan so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (rem[i]) begin
                low_idx = REGAW'(i);
            end
        end
    end

    assign rem_clr = rem & (rem - NREG'(1));

    always_comb begin
        state_nx  = state;
        rem_nx    = rem;
        reg_we_nx = 1'b0;
        reg_wa_nx = reg_wa;
        reg_wd_nx = reg_wd;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    case (in_kind)
                        KIND_NOWR: begin
                            done_nx = 1'b1;
                        end
                        KIND_SINGLE: begin
                            reg_we_nx = 1'b1;
                            reg_wa_nx = in_rd;
                            reg_wd_nx = in_data;
                            done_nx   = 1'b1;
                        end
                        KIND_LINK: begin
                            reg_we_nx = 1'b1;
                            reg_wa_nx = REGAW'(LR_IDX);
                            reg_wd_nx = in_pc + FULLW'(PC_INC);
                            done_nx   = 1'b1;
                        end
                        default: begin
                            if (in_reglist == '0) begin
                                done_nx = 1'b1;
                            end else begin
                                rem_nx   = in_reglist;
                                state_nx = MULTI;
                            end
                        end
                    endcase
                end
            end
            MULTI: begin
                if (ld_valid) begin
                    reg_we_nx = 1'b1;
                    reg_wa_nx = low_idx;
                    reg_wd_nx = ld_data;
                    rem_nx    = rem_clr;
                    if (rem_clr == '0) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rem    <= '0;
            reg_we <= 1'b0;
            reg_wa <= '0;
            reg_wd <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            rem    <= rem_nx;
            reg_we <= reg_we_nx;
            reg_wa <= reg_wa_nx;
            reg_wd <= reg_wd_nx;
            done   <= done_nx;
        end
    end

endmodule

// File: tb/tb_wb_seq.sv
// Bench for wb_seq: directed scenarios plus randomized traffic, all checked against a
// request-level model that expands register lists into a queue of pending writes.
module tb_wb_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_kind = 2'd0;
    logic [3:0]  in_rd = '0;
    logic [31:0] in_data = '0;
    logic [31:0] in_pc = '0;
    logic [15:0] in_reglist = '0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        reg_we;
    logic [3:0]  reg_wa;
    logic [31:0] reg_wd;
    logic        busy;
    logic        done;

    wb_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .in_pc      (in_pc),
        .in_reglist (in_reglist),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .reg_we     (reg_we),
        .reg_wa     (reg_wa),
        .reg_wd     (reg_wd),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: a MULTI request becomes a list of register numbers still owed a load word.
    bit          m_busy = 1'b0;
    int          m_q[$];
    logic        exp_we = 1'b0;
    logic [3:0]  exp_wa = '0;
    logic [31:0] exp_wd = '0;
    logic        exp_done = 1'b0;
    bit          last_accepted = 1'b0;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        exp_we        = 1'b0;
        exp_done      = 1'b0;
        last_accepted = 1'b0;
        if (!m_busy) begin
            if (in_valid) begin
                last_accepted = 1'b1;
                if (in_kind == 2'd0) begin
                    exp_done = 1'b1;
                end else if (in_kind == 2'd1) begin
                    exp_we   = 1'b1;
                    exp_wa   = in_rd;
                    exp_wd   = in_data;
                    exp_done = 1'b1;
                end else if (in_kind == 2'd2) begin
                    exp_we   = 1'b1;
                    exp_wa   = 4'd14;
                    exp_wd   = in_pc + 32'd4;
                    exp_done = 1'b1;
                end else begin
                    m_q.delete();
                    for (int i = 0; i < 16; i++) begin
                        if (in_reglist[i]) m_q.push_back(i);
                    end
                    if (m_q.size() == 0) exp_done = 1'b1;
                    else m_busy = 1'b1;
                end
            end
        end else if (ld_valid) begin
            exp_we = 1'b1;
            exp_wa = 4'(m_q.pop_front());
            exp_wd = ld_data;
            if (m_q.size() == 0) begin
                exp_done = 1'b1;
                m_busy   = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        chk_val("in_ready", in_ready, !m_busy);
        chk_val("busy", busy, m_busy);
        chk_val("reg_we", reg_we, exp_we);
        chk_val("done", done, exp_done);
        if (exp_we) begin
            chk_val("reg_wa", reg_wa, exp_wa);
            chk_val("reg_wd", reg_wd, exp_wd);
        end
    endtask

    // Called just after a falling edge: drive, predict, cross the rising edge, check.
    task automatic step(input logic v, input logic [1:0] k, input logic [3:0] rd,
                        input logic [31:0] d, input logic [31:0] pc, input logic [15:0] lst,
                        input logic lv, input logic [31:0] ld);
        in_valid   = v;
        in_kind    = k;
        in_rd      = rd;
        in_data    = d;
        in_pc      = pc;
        in_reglist = lst;
        ld_valid   = lv;
        ld_data    = ld;
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_step();
        step(1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b0, 32'd0);
    endtask

    initial begin
        logic        r_v;
        logic [1:0]  r_k;
        logic [3:0]  r_rd;
        logic [31:0] r_d, r_pc;
        logic [15:0] r_l;

        repeat (2) @(negedge clk);
        chk_val("rst_we", reg_we, 1'b0);
        chk_val("rst_wa", reg_wa, 4'd0);
        chk_val("rst_wd", reg_wd, 32'd0);
        chk_val("rst_done", done, 1'b0);
        chk_val("rst_busy", busy, 1'b0);
        chk_val("rst_ready", in_ready, 1'b1);
        rst = 1'b0;

        // SINGLE then idle
        step(1'b1, 2'd1, 4'd3, 32'hDEADBEEF, 32'd0, 16'd0, 1'b0, 32'd0);
        chk_val("single_wd", reg_wd, 32'hDEADBEEF);
        chk_val("single_wa", reg_wa, 4'd3);
        idle_step();
        chk_val("single_we_drop", reg_we, 1'b0);

        // LINK, including wrap
        step(1'b1, 2'd2, 4'd0, 32'd0, 32'h100, 16'd0, 1'b0, 32'd0);
        chk_val("link_wa", reg_wa, 4'd14);
        chk_val("link_wd", reg_wd, 32'h104);
        step(1'b1, 2'd2, 4'd0, 32'd0, 32'hFFFFFFFC, 16'd0, 1'b0, 32'd0);
        chk_val("link_wrap", reg_wd, 32'h0);

        // MULTI 0x8011 with load pattern 1,0,1,1
        step(1'b1, 2'd3, 4'd0, 32'd0, 32'd0, 16'h8011, 1'b0, 32'd0);
        chk_val("multi_busy", busy, 1'b1);
        step(1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b1, 32'hAAAA0000);
        chk_val("multi_r0", reg_wa, 4'd0);
        step(1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b0, 32'h0);
        chk_val("multi_stall", reg_we, 1'b0);
        step(1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b1, 32'hBBBB0000);
        chk_val("multi_r4", reg_wa, 4'd4);
        chk_val("multi_ready_low", in_ready, 1'b0);
        step(1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b1, 32'hCCCC0000);
        chk_val("multi_r15", reg_wa, 4'd15);
        chk_val("multi_done", done, 1'b1);
        chk_val("multi_ready_back", in_ready, 1'b1);

        // Empty list behaves as NOWR
        step(1'b1, 2'd3, 4'd0, 32'd0, 32'd0, 16'h0000, 1'b1, 32'h1);
        chk_val("empty_done", done, 1'b1);
        chk_val("empty_we", reg_we, 1'b0);
        chk_val("empty_busy", busy, 1'b0);

        // SINGLE held across a 2-word MULTI
        step(1'b1, 2'd3, 4'd0, 32'd0, 32'd0, 16'h0006, 1'b0, 32'd0);
        step(1'b1, 2'd1, 4'd9, 32'h12345678, 32'd0, 16'd0, 1'b0, 32'd0);
        step(1'b1, 2'd1, 4'd9, 32'h12345678, 32'd0, 16'd0, 1'b1, 32'h11);
        step(1'b1, 2'd1, 4'd9, 32'h12345678, 32'd0, 16'd0, 1'b1, 32'h22);
        chk_val("held_ready_rise", in_ready, 1'b1);
        step(1'b1, 2'd1, 4'd9, 32'h12345678, 32'd0, 16'd0, 1'b0, 32'd0);
        chk_val("held_write", reg_wa, 4'd9);
        idle_step();

        // Async reset after 2 of 4 words
        step(1'b1, 2'd3, 4'd0, 32'd0, 32'd0, 16'h00F0, 1'b0, 32'd0);
        step(1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b1, 32'h5);
        step(1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b1, 32'h6);
        #2 rst = 1'b1;
        #1;
        chk_val("rst_mid_we", reg_we, 1'b0);
        chk_val("rst_mid_busy", busy, 1'b0);
        chk_val("rst_mid_ready", in_ready, 1'b1);
        m_busy   = 1'b0;
        m_q.delete();
        exp_we   = 1'b0;
        exp_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b1, 32'h7);

        // Randomized traffic; MEM holds a refused request until accepted
        r_v = 1'b0; r_k = '0; r_rd = '0; r_d = '0; r_pc = '0; r_l = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!(r_v && !last_accepted)) begin
                r_v  = ($urandom_range(0, 9) < 6);
                r_k  = 2'($urandom_range(0, 3));
                r_rd = 4'($urandom);
                r_d  = $urandom;
                r_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
                r_l  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
            end
            step(r_v, r_k, r_rd, r_d, r_pc, r_l, ($urandom_range(0, 9) < 7), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
